cram_port_ctrl: RTL and testbench

- Two-port front end that sits directly upstream of the lab CPU's cram.
- Arbitrates between an instruction-fetch port (read-only) and a data port (read/write), and registers the winning request.
- Drives cram's address/data/we/oe for exactly one cycle per access, then returns registered read data or a write acknowledge.
- Sustains one access per cycle. The data port has priority, and a starvation counter guarantees fetch progress.

---
 rtl/cram_port_ctrl_pkg.sv | 19 +
 rtl/cram_port_arb.sv | 39 +++
 rtl/cram_port_ctrl.sv | 104 ++++++++++
 tb/tb_cram_port_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cram_port_ctrl_pkg.sv
// Shared constants and types for the cram two-port front end.
package cram_port_ctrl_pkg;

   // Port identifiers carried through the access stage
   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_DM = 1'b1;

   // Width of the fetch starvation counter (limit range 1..15)
   localparam int unsigned STARVE_W = 4;

   // Control part of the access-stage record; address and data widths are
   // module parameters, so the top wraps this with its own addr/wdata fields.
   typedef struct packed {
      logic valid;
      logic port;
      logic we;
   } acc_ctrl_t;

endpackage

// File: rtl/cram_port_arb.sv
// Fixed-priority arbiter (data port first) with a saturating starvation
// counter that forces a fetch grant after p_starve_limit consecutive losses.
module cram_port_arb
   import cram_port_ctrl_pkg::*;
#(
   parameter int unsigned p_starve_limit = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic dm_req,
   output logic grant_if,
   output logic grant_dm
);

   logic [STARVE_W-1:0] starve_cnt;
   logic                if_forced;

   // Priority decode; nothing is granted while reset is held
   always_comb begin
      if_forced = (starve_cnt == STARVE_W'(p_starve_limit));
      grant_dm  = !rst && dm_req && !(if_req && if_forced);
      grant_if  = !rst && if_req && !grant_dm;
   end

   // Count consecutive cycles a pending fetch loses, saturating at the limit
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (if_req && !grant_if) begin
         if (!if_forced) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end else begin
         starve_cnt <= '0;
      end
   end

endmodule

// File: rtl/cram_port_ctrl.sv
// Two-port (fetch / data) front end for the cram: arbitrate, register the
// winner into a one-deep access stage, drive cram for one cycle, and return
// registered read data or a write acknowledge two cycles after the grant.
module cram_port_ctrl
   import cram_port_ctrl_pkg::*;
#(
   parameter int unsigned p_data_width    = 16,
   parameter int unsigned p_address_width = 10,
   parameter int unsigned p_starve_limit  = 4
) (
   input  logic                       i_w_clk,
   input  logic                       i_w_rst,
   input  logic                       i_w_if_req,
   input  logic [p_address_width-1:0] i_w_if_addr,
   output logic                       o_w_if_gnt,
   output logic                       o_w_if_rvalid,
   output logic [p_data_width-1:0]    o_w_if_rdata,
   input  logic                       i_w_dm_req,
   input  logic                       i_w_dm_we,
   input  logic [p_address_width-1:0] i_w_dm_addr,
   input  logic [p_data_width-1:0]    i_w_dm_wdata,
   output logic                       o_w_dm_gnt,
   output logic                       o_w_dm_rvalid,
   output logic [p_data_width-1:0]    o_w_dm_rdata,
   output logic [p_address_width-1:0] o_w_mem_address,
   output logic [p_data_width-1:0]    o_w_mem_in,
   output logic                       o_w_mem_we,
   output logic                       o_w_mem_oe,
   input  logic [p_data_width-1:0]    i_w_mem_out
);

   typedef struct packed {
      acc_ctrl_t                  ctrl;
      logic [p_address_width-1:0] addr;
      logic [p_data_width-1:0]    wdata;
   } acc_t;

   acc_t acc;
   logic grant_if;
   logic grant_dm;

   cram_port_arb #(
      .p_starve_limit (p_starve_limit)
   ) u_arb (
      .clk      (i_w_clk),
      .rst      (i_w_rst),
      .if_req   (i_w_if_req),
      .dm_req   (i_w_dm_req),
      .grant_if (grant_if),
      .grant_dm (grant_dm)
   );

   // Latch the winning request; addr/wdata hold when idle so cram pins stay quiet
   always_ff @(posedge i_w_clk) begin
      if (i_w_rst) begin
         acc <= '0;
      end else begin
         acc.ctrl.valid <= grant_if || grant_dm;
         if (grant_dm) begin
            acc.ctrl.port <= PORT_DM;
            acc.ctrl.we   <= i_w_dm_we;
            acc.addr      <= i_w_dm_addr;
            if (i_w_dm_we) begin
               acc.wdata <= i_w_dm_wdata;
            end
         end else if (grant_if) begin
            acc.ctrl.port <= PORT_IF;
            acc.ctrl.we   <= 1'b0;
            acc.addr      <= i_w_if_addr;
         end
      end
   end

   // Drive cram from the access stage; strobes are masked during reset so an
   // in-flight write can never commit while reset is high
   always_comb begin
      o_w_if_gnt      = grant_if;
      o_w_dm_gnt      = grant_dm;
      o_w_mem_address = acc.addr;
      o_w_mem_in      = acc.wdata;
      o_w_mem_we      = acc.ctrl.valid && acc.ctrl.we && !i_w_rst;
      o_w_mem_oe      = acc.ctrl.valid && !acc.ctrl.we && !i_w_rst;
   end

   // Capture cram output into the owning port; write acks return zero data
   always_ff @(posedge i_w_clk) begin
      if (i_w_rst) begin
         o_w_if_rvalid <= 1'b0;
         o_w_if_rdata  <= '0;
         o_w_dm_rvalid <= 1'b0;
         o_w_dm_rdata  <= '0;
      end else begin
         o_w_if_rvalid <= acc.ctrl.valid && (acc.ctrl.port == PORT_IF);
         o_w_dm_rvalid <= acc.ctrl.valid && (acc.ctrl.port == PORT_DM);
         if (acc.ctrl.valid && (acc.ctrl.port == PORT_IF)) begin
            o_w_if_rdata <= i_w_mem_out;
         end
         if (acc.ctrl.valid && (acc.ctrl.port == PORT_DM)) begin
            o_w_dm_rdata <= acc.ctrl.we ? '0 : i_w_mem_out;
         end
      end
   end

endmodule

// File: tb/tb_cram_port_ctrl.sv
// Directed bench for cram_port_ctrl with a behavioural cram attached.
module tb_cram_port_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [9:0]  if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [15:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   logic [9:0]  dm_addr;
   logic [15:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_rvalid;
   logic [15:0] dm_rdata;
   logic [9:0]  mem_address;
   logic [15:0] mem_in;
   logic        mem_we;
   logic        mem_oe;
   logic [15:0] mem_out;

   int checks = 0;
   int errors = 0;

   logic [15:0] cram [0:1023];

   always #5 clk = ~clk;

   // cram: combinational read under oe, write commits on the falling edge
   assign mem_out = mem_oe ? cram[mem_address] : 16'h0000;
   always @(negedge clk) if (mem_we) cram[mem_address] <= mem_in;

   cram_port_ctrl #(
      .p_data_width    (16),
      .p_address_width (10),
      .p_starve_limit  (4)
   ) dut (
      .i_w_clk         (clk),
      .i_w_rst         (rst),
      .i_w_if_req      (if_req),
      .i_w_if_addr     (if_addr),
      .o_w_if_gnt      (if_gnt),
      .o_w_if_rvalid   (if_rvalid),
      .o_w_if_rdata    (if_rdata),
      .i_w_dm_req      (dm_req),
      .i_w_dm_we       (dm_we),
      .i_w_dm_addr     (dm_addr),
      .i_w_dm_wdata    (dm_wdata),
      .o_w_dm_gnt      (dm_gnt),
      .o_w_dm_rvalid   (dm_rvalid),
      .o_w_dm_rdata    (dm_rdata),
      .o_w_mem_address (mem_address),
      .o_w_mem_in      (mem_in),
      .o_w_mem_we      (mem_we),
      .o_w_mem_oe      (mem_oe),
      .i_w_mem_out     (mem_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) cram[i] = 16'h0000;
      for (int i = 0; i < 8; i++) cram[i] = 16'h0100 + 16'(i);
      cram[10'h010] = 16'h1234;
      cram[10'h020] = 16'hAAAA;

      rst = 1'b1; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 16'hFFFF;

      // Requests during reset must not be granted
      tick(); #1;
      chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      tick();
      rst = 1'b0; dm_req = 1'b0; #1;
      chk("idle_if_gnt", 32'(if_gnt), 32'd0);
      chk("idle_dm_gnt", 32'(dm_gnt), 32'd0);
      chk("idle_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("idle_if_rdata", 32'(if_rdata), 32'd0);
      chk("idle_dm_rvalid", 32'(dm_rvalid), 32'd0);
      chk("idle_dm_rdata", 32'(dm_rdata), 32'd0);
      chk("idle_mem_addr", 32'(mem_address), 32'd0);
      chk("idle_mem_in", 32'(mem_in), 32'd0);
      for (int i = 0; i < 10; i++) begin
         chk("idle_mem_we", 32'(mem_we), 32'd0);
         chk("idle_mem_oe", 32'(mem_oe), 32'd0);
         tick(); #1;
      end

      // Data write 0x005 <- 0xBEEF, then read it back the next cycle
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h005; dm_wdata = 16'hBEEF; #1;
      chk("wr_dm_gnt", 32'(dm_gnt), 32'd1);
      chk("wr_if_gnt", 32'(if_gnt), 32'd0);
      chk("wr_c0_we", 32'(mem_we), 32'd0);
      tick();
      dm_we = 1'b0; #1;
      chk("rd_dm_gnt", 32'(dm_gnt), 32'd1);
      chk("wr_c1_we", 32'(mem_we), 32'd1);
      chk("wr_c1_oe", 32'(mem_oe), 32'd0);
      chk("wr_c1_addr", 32'(mem_address), 32'h005);
      chk("wr_c1_in", 32'(mem_in), 32'hBEEF);
      chk("wr_c1_rvalid", 32'(dm_rvalid), 32'd0);
      tick();
      dm_req = 1'b0; #1;
      chk("wr_c2_we", 32'(mem_we), 32'd0);
      chk("rd_c1_oe", 32'(mem_oe), 32'd1);
      chk("rd_c1_addr", 32'(mem_address), 32'h005);
      chk("wr_ack_rvalid", 32'(dm_rvalid), 32'd1);
      chk("wr_ack_rdata", 32'(dm_rdata), 32'd0);
      tick(); #1;
      chk("rd_rvalid", 32'(dm_rvalid), 32'd1);
      chk("rd_rdata", 32'(dm_rdata), 32'hBEEF);
      chk("rd_c2_oe", 32'(mem_oe), 32'd0);
      chk("cram_005", 32'(cram[10'h005]), 32'hBEEF);
      tick(); #1;
      chk("rd_rvalid_pulse", 32'(dm_rvalid), 32'd0);
      chk("rd_rdata_hold", 32'(dm_rdata), 32'hBEEF);

      // Single fetch read of 0x010
      if_req = 1'b1; if_addr = 10'h010; #1;
      chk("if_gnt", 32'(if_gnt), 32'd1);
      tick();
      if_req = 1'b0; #1;
      chk("if_c1_oe", 32'(mem_oe), 32'd1);
      chk("if_c1_addr", 32'(mem_address), 32'h010);
      chk("if_c1_rvalid", 32'(if_rvalid), 32'd0);
      tick(); #1;
      chk("if_rvalid", 32'(if_rvalid), 32'd1);
      chk("if_rdata", 32'(if_rdata), 32'h1234);
      chk("if_dm_rvalid", 32'(dm_rvalid), 32'd0);
      tick(); #1;
      chk("if_rvalid_pulse", 32'(if_rvalid), 32'd0);

      // Both ports request continuously: fetch wins every 5th cycle
      if_req = 1'b1; if_addr = 10'h010;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h005; #1;
      for (int k = 0; k < 10; k++) begin
         chk("starve_if_gnt", 32'(if_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
         chk("starve_dm_gnt", 32'(dm_gnt), (k % 5 == 4) ? 32'd0 : 32'd1);
         chk("starve_oe_we", 32'(mem_oe && mem_we), 32'd0);
         tick(); #1;
      end
      if_req = 1'b0; dm_req = 1'b0;
      tick(); tick(); tick(); #1;

      // Reset lands while a data write to 0x020 sits in the access stage
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h020; dm_wdata = 16'h5555; #1;
      chk("rw_dm_gnt", 32'(dm_gnt), 32'd1);
      tick();
      dm_req = 1'b0; rst = 1'b1; if_req = 1'b1; if_addr = 10'h003; #1;
      chk("rw_mem_we", 32'(mem_we), 32'd0);
      chk("rw_if_gnt_in_rst", 32'(if_gnt), 32'd0);
      tick();
      rst = 1'b0; #1;
      chk("rw_if_gnt_after", 32'(if_gnt), 32'd1);
      chk("rw_dm_rvalid_0", 32'(dm_rvalid), 32'd0);
      chk("rw_mem_we_0", 32'(mem_we), 32'd0);
      tick();
      if_req = 1'b0; #1;
      chk("rw_dm_rvalid_1", 32'(dm_rvalid), 32'd0);
      chk("rw_if_oe", 32'(mem_oe), 32'd1);
      chk("rw_if_addr", 32'(mem_address), 32'h003);
      tick(); #1;
      chk("rw_dm_rvalid_2", 32'(dm_rvalid), 32'd0);
      chk("rw_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("rw_if_rdata", 32'(if_rdata), 32'h0103);
      chk("rw_cram_020", 32'(cram[10'h020]), 32'hAAAA);

      // Back-to-back fetch reads of 0x000..0x007 (0x005 was rewritten to 0xBEEF)
      tick();
      for (int k = 0; k < 10; k++) begin
         if_req = (k < 8); if_addr = 10'(k); #1;
         if (k < 8) chk("b2b_if_gnt", 32'(if_gnt), 32'd1);
         if (k >= 2) begin
            chk("b2b_rvalid", 32'(if_rvalid), 32'd1);
            chk("b2b_rdata", 32'(if_rdata), (k - 2 == 5) ? 32'hBEEF : 32'h0100 + 32'(k - 2));
         end else begin
            chk("b2b_rvalid_lead", 32'(if_rvalid), 32'd0);
         end
         tick();
      end
      #1;
      chk("b2b_rvalid_end", 32'(if_rvalid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
